// File: rtl/ipv6_header_assembler_if.sv
// Stream-side and header-side handshake bundle for ipv6_header_assembler.
// Input side: DW-wide valid/ready word stream. Output side: 320-bit header
// with valid/ready and a one-cycle error pulse.
interface ipv6_header_assembler_if #(
    parameter int DW = 32
);
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          o_valid;
    logic          o_ready;
    logic [319:0]  o_head;
    logic          o_err;

    // The assembler sits on the slave side of this bundle
    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output i_ready, o_valid, o_head, o_err
    );

    // Stream source / header consumer
    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  i_ready, o_valid, o_head, o_err
    );
endinterface

// File: rtl/ipv6_header_assembler.sv
// IPv6 fixed-header assembler: collects a 320-bit header from a DW-wide word
// stream (network order, first word = header MSBs), presents it on a
// valid/ready output, drops payload words up to end-of-packet and pulses
// o_err on short packets.
// Optional build macro IPV6_VERSION_CHECK_EN: reject headers whose Version
// field is not 6 (error pulse instead of presenting the header).

package package_ipv6;
    typedef struct packed {
        logic [3:0]   version;
        logic [7:0]   traffic_class;
        logic [19:0]  flow_label;
        logic [15:0]  payload_length;
        logic [7:0]   next_header;
        logic [7:0]   hop_limit;
        logic [127:0] src_addr;
        logic [127:0] dst_addr;
    } t_ipv6_header;
endpackage

module ipv6_header_assembler #(
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ipv6_header_assembler_if.slave  bus
);
    import package_ipv6::*;

    localparam int HW = $bits(t_ipv6_header);
    localparam int N  = HW / DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SLOT  = CW'(N - 1);
    localparam logic [HW-1:0] RESET_HEAD = {4'd6, {(HW - 4){1'b0}}};

    // Only widths that tile the header exactly are supported
    generate
        if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64 || DW == 160 || DW == 320)) begin : g_bad_dw
            $error("ipv6_header_assembler: DW=%0d is not a legal word width", DW);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_COLLECT,
        S_SKIP,
        S_HOLD
    } t_state;

    t_state        r_state;
    t_state        w_state_next;
    logic [CW-1:0] r_cnt;
    t_ipv6_header  r_head;
    logic          r_valid;
    logic          r_err;

    logic          w_ready;
    logic          w_accept;
    logic          w_collect_accept;
    logic          w_complete;
    logic          w_short;
    logic          w_fire;
    logic          w_valid_hold;
    logic          w_head_ok;
    logic [HW-1:0] w_assembled;

    // i_ready depends only on state and reset, never on i_valid
    assign w_ready          = !rst && (r_state != S_HOLD);
    assign w_accept         = bus.i_valid && w_ready;
    assign w_collect_accept = w_accept && (r_state == S_COLLECT);
    assign w_complete       = w_collect_accept && (r_cnt == LAST_SLOT);
    assign w_short          = w_collect_accept && bus.i_last && (r_cnt != LAST_SLOT);
    assign w_fire           = r_valid && bus.o_ready;
    assign w_valid_hold     = r_valid && !bus.o_ready;

    // Staging: one register per header word except the last, which is
    // taken straight from i_data at completion
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_slot
            logic [DW-1:0] r_word;

            // Capture the word that lands on this slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_collect_accept && (r_cnt == CW'(gi))) begin
                    r_word <= bus.i_data;
                end
            end

            assign w_assembled[HW - 1 - gi * DW -: DW] = r_word;
        end
    endgenerate

    assign w_assembled[DW-1:0] = bus.i_data;

`ifdef IPV6_VERSION_CHECK_EN
    assign w_head_ok = (w_assembled[HW-1 -: 4] == 4'd6);
`else
    assign w_head_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: HOLD blocks input until the presented header is taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_complete) begin
                    w_state_next = bus.i_last ? S_HOLD : S_SKIP;
                end
            end
            S_SKIP: begin
                if (w_accept && bus.i_last) begin
                    w_state_next = w_valid_hold ? S_HOLD : S_COLLECT;
                end
            end
            S_HOLD: begin
                if (!w_valid_hold) begin
                    w_state_next = S_COLLECT;
                end
            end
            default: w_state_next = S_COLLECT;
        endcase
    end

    // Word counter, output header register, valid and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_head  <= RESET_HEAD;
        end else begin
            r_err <= 1'b0;
            if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (w_complete) begin
                r_cnt <= '0;
                if (w_head_ok) begin
                    r_head  <= w_assembled;
                    r_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_short) begin
                r_cnt <= '0;
                r_err <= 1'b1;
            end else if (w_collect_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.i_ready = w_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_head  = r_head;
    assign bus.o_err   = r_err;

endmodule
